// File: rtl/dht11_sensor_emulator.sv
// DHT11 sensor emulator: answers a host start pulse on an open-drain line with
// the response preamble followed by a 40-bit humidity/temperature frame.
module dht11_sensor_emulator #(
   parameter int US_CYCLES        = 100,
   parameter int START_LOW_MIN_US = 18000,
   parameter int RESP_DELAY_US    = 30,
   parameter int RESP_LOW_US      = 80,
   parameter int RESP_HIGH_US     = 80,
   parameter int BIT_LOW_US       = 50,
   parameter int BIT0_HIGH_US     = 28,
   parameter int BIT1_HIGH_US     = 70
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rh_int,
   input  logic [7:0] rh_dec,
   input  logic [7:0] t_int,
   input  logic [7:0] t_dec,
   input  logic       bad_crc,
   inout  wire        dht11_io,
   output logic       busy,
   output logic       done,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_HOST_LOW  = 4'd1,
      ST_WAIT_REL  = 4'd2,
      ST_RESP_LOW  = 4'd3,
      ST_RESP_HIGH = 4'd4,
      ST_BIT_LOW   = 4'd5,
      ST_BIT_HIGH  = 4'd6,
      ST_END_LOW   = 4'd7
   } state_t;

   localparam logic [23:0] START_LIM  = 24'(START_LOW_MIN_US * US_CYCLES - 1);
   localparam logic [23:0] DELAY_LIM  = 24'(RESP_DELAY_US * US_CYCLES - 1);
   localparam logic [23:0] RLOW_LIM   = 24'(RESP_LOW_US * US_CYCLES - 1);
   localparam logic [23:0] RHIGH_LIM  = 24'(RESP_HIGH_US * US_CYCLES - 1);
   localparam logic [23:0] BLOW_LIM   = 24'(BIT_LOW_US * US_CYCLES - 1);
   localparam logic [23:0] B0HIGH_LIM = 24'(BIT0_HIGH_US * US_CYCLES - 1);
   localparam logic [23:0] B1HIGH_LIM = 24'(BIT1_HIGH_US * US_CYCLES - 1);

   // Checksum byte, optionally corrupted in its LSB for negative testing.
   function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d,
                                            input logic flip);
      logic [7:0] s;
      s = a + b + c + d;
      return s ^ {7'd0, flip};
   endfunction

   state_t      state_r;
   state_t      next_state_s;
   logic        io_meta_r;
   logic        io_s;
   logic [23:0] cnt_r;
   logic [5:0]  bit_idx_r;
   logic [39:0] frame_r;
   logic        drive_low_r;
   logic        busy_r;
   logic        done_r;
   logic [5:0]  bit_sel_s;
   logic        latch_s;

   assign dht11_io  = drive_low_r ? 1'b0 : 1'bz;
   assign busy      = busy_r;
   assign done      = done_r;
   assign state     = state_r;
   assign bit_sel_s = 6'd39 - bit_idx_r;
   assign latch_s   = (state_r == ST_HOST_LOW) && (next_state_s == ST_WAIT_REL);

   // Two-flop synchronizer for the asynchronous bus input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_meta_r <= 1'b1;
         io_s      <= 1'b1;
      end else begin
         io_meta_r <= dht11_io;
         io_s      <= io_meta_r;
      end
   end

   // Next-state decode; each timed phase ends when cnt_r reaches its limit.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!io_s) next_state_s = ST_HOST_LOW;
            else       next_state_s = ST_IDLE;
         end
         ST_HOST_LOW: begin
            if (io_s) begin
               if (cnt_r >= START_LIM) next_state_s = ST_WAIT_REL;
               else                    next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_HOST_LOW;
            end
         end
         ST_WAIT_REL: begin
            if (cnt_r == DELAY_LIM) next_state_s = ST_RESP_LOW;
            else                    next_state_s = ST_WAIT_REL;
         end
         ST_RESP_LOW: begin
            if (cnt_r == RLOW_LIM) next_state_s = ST_RESP_HIGH;
            else                   next_state_s = ST_RESP_LOW;
         end
         ST_RESP_HIGH: begin
            if (cnt_r == RHIGH_LIM) next_state_s = ST_BIT_LOW;
            else                    next_state_s = ST_RESP_HIGH;
         end
         ST_BIT_LOW: begin
            if (cnt_r == BLOW_LIM) next_state_s = ST_BIT_HIGH;
            else                   next_state_s = ST_BIT_LOW;
         end
         ST_BIT_HIGH: begin
            if (cnt_r == (frame_r[bit_sel_s] ? B1HIGH_LIM : B0HIGH_LIM)) begin
               if (bit_idx_r == 6'd39) next_state_s = ST_END_LOW;
               else                    next_state_s = ST_BIT_LOW;
            end else begin
               next_state_s = ST_BIT_HIGH;
            end
         end
         ST_END_LOW: begin
            if (cnt_r == BLOW_LIM) next_state_s = ST_IDLE;
            else                   next_state_s = ST_END_LOW;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register and saturating phase counter, cleared on every transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 24'd0;
      end else begin
         state_r <= next_state_s;
         if (next_state_s != state_r) cnt_r <= 24'd0;
         else if (cnt_r != 24'hFF_FFFF) cnt_r <= cnt_r + 24'd1;
         else cnt_r <= cnt_r;
      end
   end

   // Frame capture at start acceptance and bit index sequencing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_r   <= 40'd0;
         bit_idx_r <= 6'd0;
      end else begin
         if (latch_s)
            frame_r <= {rh_int, rh_dec, t_int, t_dec,
                        frame_sum(rh_int, rh_dec, t_int, t_dec, bad_crc)};
         if (state_r == ST_RESP_HIGH && next_state_s == ST_BIT_LOW)
            bit_idx_r <= 6'd0;
         else if (state_r == ST_BIT_HIGH && next_state_s == ST_BIT_LOW)
            bit_idx_r <= bit_idx_r + 6'd1;
      end
   end

   // Outputs decoded from next state so the bus moves on the transition edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drive_low_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         drive_low_r <= (next_state_s == ST_RESP_LOW) || (next_state_s == ST_BIT_LOW) ||
                        (next_state_s == ST_END_LOW);
         busy_r      <= (next_state_s >= ST_WAIT_REL) && (next_state_s <= ST_END_LOW);
         done_r      <= (state_r == ST_END_LOW) && (next_state_s == ST_IDLE);
      end
   end

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Self-checking bench: acts as the DHT11 host, measures bus phase widths and
// decodes the frame, comparing against frames computed from the payload rules.
module tb_dht11_sensor_emulator;

   localparam int US  = 1;
   localparam int LIM = 2000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rh_int, rh_dec, t_int, t_dec;
   logic       bad_crc;
   logic       host_low;
   wire        dht11_io;
   logic       busy, done;
   logic [3:0] state;

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   bit stuck = 1'b0;

   always #5 clk = ~clk;

   assign dht11_io = host_low ? 1'b0 : 1'bz;
   pullup (dht11_io);

   dht11_sensor_emulator #(.US_CYCLES(US), .START_LOW_MIN_US(100)) dut (
      .clk(clk), .rst(rst), .rh_int(rh_int), .rh_dec(rh_dec), .t_int(t_int),
      .t_dec(t_dec), .bad_crc(bad_crc), .dht11_io(dht11_io), .busy(busy),
      .done(done), .state(state)
   );

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
      n_chk++;
      if (got > exp + tol || got < exp - tol) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) +/-%0d",
                  tag, got, got, exp, exp, tol);
      end
   endtask

   // Counts consecutive negedge samples (including the current one) at level lvl.
   task automatic measure(input logic lvl, output int w);
      w = 0;
      if (stuck) return;
      while (((dht11_io !== 1'b0) == lvl) && w < LIM) begin
         w++;
         @(negedge clk);
      end
      if (w >= LIM) begin
         stuck = 1'b1;
         chk("bus_timeout", w, 0, 0);
      end
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic bad, input int abort_bit);
      logic [7:0]  s;
      logic [39:0] exp, got;
      int          w, start_done;
      logic        bit_v;
      @(negedge clk);
      rh_int = a; rh_dec = b; t_int = c; t_dec = d; bad_crc = bad;
      s = a + b + c + d;
      s = s ^ {7'd0, bad};
      exp = {a, b, c, d, s};
      start_done = done_cnt;
      host_low = 1'b1;
      repeat (150 * US) @(negedge clk);
      host_low = 1'b0;
      @(negedge clk);
      measure(1'b1, w); chk("resp_delay", w, 30 * US + 2, 1);
      rh_int = 8'($urandom); rh_dec = 8'($urandom); t_int = 8'($urandom);
      t_dec = 8'($urandom); bad_crc = ~bad;
      chk("busy_in_frame", busy, 1, 0);
      measure(1'b0, w); chk("resp_low", w, 80 * US, 1);
      measure(1'b1, w); chk("resp_high", w, 80 * US, 1);
      got = 40'd0;
      for (int i = 0; i < 40; i++) begin
         if (i == abort_bit) begin
            repeat (5) @(negedge clk);
            chk("pre_rst_driven", (dht11_io === 1'b0), 1, 0);
            rst = 1'b1;
            #1;
            chk("rst_bus_release", (dht11_io !== 1'b0), 1, 0);
            chk("rst_state", state, 0, 0);
            chk("rst_busy", busy, 0, 0);
            @(negedge clk); @(negedge clk);
            rst = 1'b0;
            repeat (20) @(negedge clk);
            chk("rst_no_done", done_cnt, start_done, 0);
            chk("rst_idle", state, 0, 0);
            return;
         end
         measure(1'b0, w); chk($sformatf("bit%0d_low", i), w, 50 * US, 1);
         measure(1'b1, w);
         chk($sformatf("bit%0d_high", i), w, exp[39 - i] ? 70 * US : 28 * US, 1);
         bit_v = (w > 49 * US);
         got = {got[38:0], bit_v};
      end
      measure(1'b0, w); chk("end_low", w, 50 * US, 1);
      chk("done_pulse", done, 1, 0);
      chk("end_state", state, 0, 0);
      chk("end_busy", busy, 0, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0, 0);
      chk("done_count", done_cnt, start_done + 1, 0);
      chk("frame", got, exp, 0);
   endtask

   initial begin
      int w, low_seen, busy_seen;
      rst = 1'b1; host_low = 1'b0;
      rh_int = 8'd0; rh_dec = 8'd0; t_int = 8'd0; t_dec = 8'd0; bad_crc = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", state, 0, 0);
      chk("reset_busy", busy, 0, 0);
      chk("reset_done", done, 0, 0);
      chk("reset_bus", (dht11_io !== 1'b0), 1, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      run_frame(8'hAA, 8'h0F, 8'hC6, 8'h00, 1'b0, -1);
      run_frame(8'hAA, 8'h0F, 8'hC6, 8'h00, 1'b1, -1);

      // Short start pulse must be rejected without any response.
      @(negedge clk);
      host_low = 1'b1;
      repeat (60 * US) @(negedge clk);
      host_low = 1'b0;
      low_seen = 0; busy_seen = 0;
      repeat (300 * US) begin
         @(negedge clk);
         if (dht11_io === 1'b0) low_seen++;
         if (busy) busy_seen++;
      end
      chk("short_bus_driven", low_seen, 0, 0);
      chk("short_busy", busy_seen, 0, 0);
      chk("short_state", state, 0, 0);

      run_frame(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, -1);
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 12);
      repeat (3)
         run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom_range(1, 0)), -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dht11_sensor_emulator.md
# dht11_sensor_emulator

Synthesizable single-wire responder that emulates a DHT11 humidity/temperature sensor on the open-drain `dht11_io` line. It detects the host start pulse, answers with the DHT11 response preamble, and then shifts out a 40-bit frame: RH integer, RH decimal, T integer, T decimal, checksum. It sits on the board-side end of the bus opposite `dht11_controller`, and serves as a loopback target for hardware bring-up and as a reusable bench model.

## Interface
- `US_CYCLES`, default 100: clock cycles per microsecond (100 MHz clock).
- `START_LOW_MIN_US`, default 18000: minimum host low time accepted as a start request.
- `RESP_DELAY_US`, default 30: time from host release to the sensor pulling low.
- `RESP_LOW_US`, default 80; `RESP_HIGH_US`, default 80: response preamble phases.
- `BIT_LOW_US`, default 50: low sync time before each bit and after the last bit.
- `BIT0_HIGH_US`, default 28; `BIT1_HIGH_US`, default 70: high time encoding a 0 or a 1.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `rh_int`, `rh_dec`, `t_int`, `t_dec`  input  8 each  payload bytes.
- `bad_crc`  input  1  when high, the transmitted checksum is XORed with 8'h01.
- `dht11_io`  inout  1  open-drain bus; driven 1'b0 or 1'bz only, with an external pull-up.
- `busy`  output  1  high from WAIT_REL through END_LOW.
- `done`  output  1  one-cycle pulse when a frame completes.
- `state`  output  4  current FSM encoding, for LEDs.

## Operation
- The bus input passes through a 2-flop synchronizer (`io_s`). FSM decisions use only `io_s`.
- A single cycle counter `cnt` (24 bits) is cleared on every state change. A phase ends when `cnt == N*US_CYCLES-1`.
- FSM states and transitions (`state` encoding in brackets):
  - IDLE [0]: bus released. `io_s==0` → HOST_LOW.
  - HOST_LOW [1]: count while `io_s==0`. When `io_s` rises:
    - if `cnt >= START_LOW_MIN_US*US_CYCLES-1` → WAIT_REL, and latch the frame;
    - otherwise → IDLE (glitch or short pulse rejected).
  - WAIT_REL [2]: released for RESP_DELAY_US → RESP_LOW.
  - RESP_LOW [3]: drive low for RESP_LOW_US → RESP_HIGH.
  - RESP_HIGH [4]: release for RESP_HIGH_US → BIT_LOW, with `bit_idx=0`.
  - BIT_LOW [5]: drive low for BIT_LOW_US → BIT_HIGH.
  - BIT_HIGH [6]: release for BIT0_HIGH_US or BIT1_HIGH_US, selected by `frame[39-bit_idx]`.
    - if `bit_idx==39` → END_LOW;
    - otherwise increment `bit_idx` → BIT_LOW.
  - END_LOW [7]: drive low for BIT_LOW_US → IDLE, pulse `done`.
- Frame latch: `{rh_int, rh_dec, t_int, t_dec, sum}`, where `sum = (rh_int+rh_dec+t_int+t_dec) mod 256`, XOR 8'h01 if `bad_crc`. Inputs are sampled once, in the latch cycle. Later input changes do not affect the frame in flight.
- From WAIT_REL to END_LOW the bus input is ignored; no collision detection.
- MSB is sent first.

## Timing
- Reset values: `dht11_io=Z` (`drive_low=0`), `busy=0`, `done=0`, `state=0`, `cnt=0`, `bit_idx=0`, frame=0.
- `drive_low` is registered. The bus changes one cycle after a state transition, or on the clock edge of the transition when decoded from next-state. Decode from next-state so phase widths are exactly N*US_CYCLES cycles.
- Host-release detection latency: 2 cycles (synchronizer). The WAIT_REL duration is measured from `io_s` rising, so the pull-low follows the physical release by RESP_DELAY_US plus 2 cycles.
- Total response after release: 30+80+80 µs, then 40 bits, then 50 µs. For an all-zero frame: 40×78 µs. Each 1 bit adds 42 µs.
- `done` is asserted in the first IDLE cycle and lasts exactly one cycle. `busy` falls in the same cycle.
- A new start accepted in IDLE right after `done` is serviced normally.
- Reset asserted mid-frame: immediate (asynchronous) bus release and return to IDLE; no `done` pulse.
- A host low that never releases holds HOST_LOW. `cnt` saturates at all-ones and does not wrap.

## Test plan
- Run benches with `START_LOW_MIN_US=100`.
- Normal frame: host low 150 µs then release; payload 0xAA,0x0F,0xC6,0x00. Expect low at +30 µs for 80 µs, high 80 µs, then 40 bits decoding to 0xAA0FC6007F. `done` pulses once, 50 µs after the last bit's high phase.
- Bad checksum: same payload with `bad_crc=1`. Expect checksum byte 0x7E.
- Short start: host low 60 µs. Expect `state` returns to 0, bus never driven, `busy` stays 0.
- Bit timing: payload 0xFF,0x00,0x00,0x00. Measure high widths: first 8 bits 7000±1 cycles, remaining data bits 2800±1 cycles. Every sync low is 5000±1 cycles.
- Reset mid-frame: assert `rst` during bit 12's low phase. Expect bus Z within the same cycle, `state=0`, no `done`. A following valid start yields a complete correct frame.
- Loopback: connect to `dht11_controller` with a pull-up and payload 0x37,0x00,0x19,0x00. Expect controller `rhdata=0x37`, `t_data=0x19`, `dht11_valid=1`.
